sad_best_k_tracker: RTL and testbench
=====================================

# sad_best_k_tracker

Running best-K tracker for the block-matching motion-estimation datapath. It sits after the SAD accumulator. It consumes one (x, y, SAD) candidate per cycle over a search window and keeps the NUM_BEST lowest-SAD candidates as a sorted list with their coordinates. It reports completion with a Done flag that it holds until the next search starts. Compared with the single-minimum comparator, it adds a parametrised depth, explicit start/last framing, a valid qualifier, defined tie-breaking and an asynchronous reset.

## Interface
Parameters:
- SAD_W, 32, SAD width; values are unsigned.
- COORD_W, 32, width of each x and y coordinate; values are unsigned.
- NUM_BEST, 2, number of list slots, legal range 1..8.
- CNT_W, 16, width of the candidate counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous reset, active-high.
- Start  in  1  one-cycle pulse; clears the list and begins a search.
- InValid  in  1  the candidate on InX/InY/InSad is present this cycle.
- InLast  in  1  with InValid, marks the final candidate of the search.
- InX, InY  in  COORD_W each  candidate coordinates.
- InSad  in  SAD_W  candidate SAD.
- BestSad  out  NUM_BEST*SAD_W  slot i in bits [i*SAD_W +: SAD_W]; slot 0 holds the lowest SAD.
- BestX, BestY  out  NUM_BEST*COORD_W  coordinates per slot, packed the same way as BestSad.
- BestValid  out  NUM_BEST  bit i is set when slot i holds a real candidate.
- Count  out  CNT_W  number of candidates accepted in the current search; saturates at all-ones.
- Busy  out  1  the block is in state SEARCH.
- Done  out  1  the block is in state DONE; the result is stable.

## Operation
States and transitions:
- IDLE: Start moves to SEARCH. InValid is ignored.
- SEARCH: InValid && InLast moves to DONE.
- DONE: Start moves to SEARCH. InValid is ignored.

Clearing:
- Start clears every slot to SAD = all-ones, x = y = 0, BestValid = 0.
- Start also sets Count = 0.
- Start is honoured in every state. In SEARCH it aborts the current search and restarts.

Insertion (applies to each InValid cycle in SEARCH):
- Compute lt[i] = (InSad < BestSad[i]) as a strict, unsigned comparison.
- Because the list is sorted, lt forms a thermometer code.
- The candidate goes into the lowest slot j with lt[j] set.
- Slots j..NUM_BEST-2 shift up by one place. The old slot NUM_BEST-1 is discarded.
- If no lt bit is set, the list is unchanged.
- BestValid shifts together with the slots, and the inserted slot's bit is set.

Rules:
- Ties keep the earlier candidate, so on equal SAD the earliest arrival ranks higher.
- An InSad of all-ones is never inserted, but it is still counted.
- Count increments on every accepted InValid cycle in SEARCH, including the InLast cycle, and saturates.
- Simultaneous Start and InValid (any state): Start wins, the list is cleared, and the candidate is dropped and not counted.
- An InLast candidate is inserted in the same edge that enters DONE.
- Outputs are registered. They hold their values in IDLE and DONE.

## Timing
- Reset values: state IDLE, all BestSad = all-ones, all BestX = BestY = 0, BestValid = 0, Count = 0, Busy = 0, Done = 0.
- Reset is asynchronous. Asserting Rst mid-search returns the block immediately to the reset values, and any partial result is lost.
- Candidate latency: a candidate sampled at edge n is visible on the Best* outputs and Count after edge n.
- Done rises after the edge that samples InValid && InLast. It stays high until the edge that samples Start, or until Rst.
- Busy rises after the Start edge and falls together with the edge that raises Done.
- Throughput: one candidate per cycle with no stalls. There is no backpressure.
- The minimum interval from Start to Done is 1 cycle, when the first candidate is also the last.

## Test plan
- Reset, then Start, then NUM_BEST=2 candidates SAD 50@(1,1), 30@(2,2), 40@(3,3), 10@(4,4)+Last -> Done=1; slot0 = 10@(4,4), slot1 = 30@(2,2); Count = 4; BestValid = 2'b11.
- Tie: SAD 20@(0,0), then 20@(5,5)+Last with NUM_BEST=1 -> slot0 = 20@(0,0); Count = 2.
- Sparse valid: Start, then a single InValid of SAD 7@(3,9)+Last, with InValid low on the other cycles -> BestValid = 2'b01, slot1 SAD = all-ones; Done rises on the cycle after.
- Restart: Start, 2 candidates, then Start together with InValid of SAD 1 -> list cleared, Count = 0, the SAD-1 candidate is absent; the next search completes normally.
- Rst asserted mid-search between clock edges -> outputs take their reset values immediately; Start after reset release works.
- Boundary: InSad = all-ones candidates only, then Last -> BestValid = 0, Count equals the number sent; InValid in IDLE or DONE leaves all outputs unchanged.

Source files
------------

// File: rtl/sad_best_k_tracker.sv
// sad_best_k_tracker
//   Keeps the NUM_BEST lowest-SAD candidates of a motion-estimation search
//   window as a sorted list (slot 0 = lowest SAD) together with their
//   coordinates. One candidate per cycle, no backpressure.
//
// Ports
//   Clk, Rst        clock, asynchronous active-high reset
//   Start           one-cycle pulse: clear list and counter, enter SEARCH
//   InValid/InLast  candidate qualifier / final candidate of the search
//   InX, InY, InSad candidate coordinates and SAD (unsigned)
//   BestSad/X/Y     packed per slot, slot i at [i*W +: W]
//   BestValid       bit i set when slot i holds a real candidate
//   Count           candidates accepted this search (saturating)
//   Busy, Done      state is SEARCH / DONE
module sad_best_k_tracker #(
  parameter int SAD_W    = 32,
  parameter int COORD_W  = 32,
  parameter int NUM_BEST = 2,
  parameter int CNT_W    = 16
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start,
  input  logic                        InValid,
  input  logic                        InLast,
  input  logic [COORD_W-1:0]          InX,
  input  logic [COORD_W-1:0]          InY,
  input  logic [SAD_W-1:0]            InSad,
  output logic [NUM_BEST*SAD_W-1:0]   BestSad,
  output logic [NUM_BEST*COORD_W-1:0] BestX,
  output logic [NUM_BEST*COORD_W-1:0] BestY,
  output logic [NUM_BEST-1:0]         BestValid,
  output logic [CNT_W-1:0]            Count,
  output logic                        Busy,
  output logic                        Done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  logic [SAD_W-1:0]     r_sad [NUM_BEST];
  logic [COORD_W-1:0]   r_x   [NUM_BEST];
  logic [COORD_W-1:0]   r_y   [NUM_BEST];
  logic [NUM_BEST-1:0]  r_vld;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic [NUM_BEST-1:0]  w_lt;
  logic [SAD_W-1:0]     w_sad_nxt [NUM_BEST];
  logic [COORD_W-1:0]   w_x_nxt   [NUM_BEST];
  logic [COORD_W-1:0]   w_y_nxt   [NUM_BEST];
  logic [NUM_BEST-1:0]  w_vld_nxt;
  logic                 w_accept;

  // Saturating increment of the candidate counter.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  // Start has priority over a coincident candidate: the candidate is dropped.
  assign w_accept = (r_state == ST_SEARCH) && InValid && !Start;

  // Insertion network. Strict less-than makes ties rank the earlier arrival
  // higher, and an all-ones SAD can never beat an empty (all-ones) slot.
  // Because the list is sorted, w_lt is a thermometer code: slot i takes the
  // new candidate where the code starts, and the slot below it otherwise.
  always_comb begin
    for (int i = 0; i < NUM_BEST; i++) begin
      w_lt[i]      = (InSad < r_sad[i]);
      w_sad_nxt[i] = r_sad[i];
      w_x_nxt[i]   = r_x[i];
      w_y_nxt[i]   = r_y[i];
    end
    w_vld_nxt = r_vld;

    if (w_lt[0]) begin
      w_sad_nxt[0] = InSad;
      w_x_nxt[0]   = InX;
      w_y_nxt[0]   = InY;
      w_vld_nxt[0] = 1'b1;
    end
    for (int i = 1; i < NUM_BEST; i++) begin
      if (w_lt[i]) begin
        if (w_lt[i-1]) begin
          w_sad_nxt[i] = r_sad[i-1];
          w_x_nxt[i]   = r_x[i-1];
          w_y_nxt[i]   = r_y[i-1];
          w_vld_nxt[i] = r_vld[i-1];
        end else begin
          w_sad_nxt[i] = InSad;
          w_x_nxt[i]   = InX;
          w_y_nxt[i]   = InY;
          w_vld_nxt[i] = 1'b1;
        end
      end
    end
  end

  // Control FSM and list registers; the InLast candidate is written on the
  // same edge that enters DONE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_vld   <= '0;
      for (int i = 0; i < NUM_BEST; i++) begin
        r_sad[i] <= {SAD_W{1'b1}};
        r_x[i]   <= '0;
        r_y[i]   <= '0;
      end
    end else if (Start) begin
      r_state <= ST_SEARCH;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_vld   <= '0;
      for (int i = 0; i < NUM_BEST; i++) begin
        r_sad[i] <= {SAD_W{1'b1}};
        r_x[i]   <= '0;
        r_y[i]   <= '0;
      end
    end else if (w_accept) begin
      r_cnt <= f_sat_inc(r_cnt);
      r_vld <= w_vld_nxt;
      for (int i = 0; i < NUM_BEST; i++) begin
        r_sad[i] <= w_sad_nxt[i];
        r_x[i]   <= w_x_nxt[i];
        r_y[i]   <= w_y_nxt[i];
      end
      if (InLast) begin
        r_state <= ST_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BEST; g++) begin : g_pack
      assign BestSad[g*SAD_W +: SAD_W]     = r_sad[g];
      assign BestX[g*COORD_W +: COORD_W]   = r_x[g];
      assign BestY[g*COORD_W +: COORD_W]   = r_y[g];
    end
  endgenerate

  assign BestValid = r_vld;
  assign Count     = r_cnt;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_sad_best_k_tracker.sv
module tb_sad_best_k_tracker;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic        InValid = 1'b0;
  logic        InLast = 1'b0;
  logic [31:0] InX = '0;
  logic [31:0] InY = '0;
  logic [31:0] InSad = '0;

  // Two-slot instance with default widths
  logic [63:0] BestSad2, BestX2, BestY2;
  logic [1:0]  BestValid2;
  logic [15:0] Count2;
  logic        Busy2, Done2;

  // One-slot instance with a 2-bit counter (tie and saturation checks)
  logic [31:0] BestSad1, BestX1, BestY1;
  logic [0:0]  BestValid1;
  logic [1:0]  Count1;
  logic        Busy1, Done1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  sad_best_k_tracker #(.SAD_W(32), .COORD_W(32), .NUM_BEST(2), .CNT_W(16)) dut2 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .InValid(InValid), .InLast(InLast),
    .InX(InX), .InY(InY), .InSad(InSad),
    .BestSad(BestSad2), .BestX(BestX2), .BestY(BestY2), .BestValid(BestValid2),
    .Count(Count2), .Busy(Busy2), .Done(Done2));

  sad_best_k_tracker #(.SAD_W(32), .COORD_W(32), .NUM_BEST(1), .CNT_W(2)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .InValid(InValid), .InLast(InLast),
    .InX(InX), .InY(InY), .InSad(InSad),
    .BestSad(BestSad1), .BestX(BestX1), .BestY(BestY1), .BestValid(BestValid1),
    .Count(Count1), .Busy(Busy1), .Done(Done1));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] x, input logic [31:0] y,
                      input logic last);
    InValid = 1'b1; InSad = s; InX = x; InY = y; InLast = last;
    step();
    InValid = 1'b0; InLast = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    #12;
    n_cmp++; if (BestSad2 !== {ONES, ONES}) begin n_fail++; $display("FAIL rst_sad got %h want %h", BestSad2, {ONES, ONES}); end
    n_cmp++; if ({BestX2, BestY2} !== 128'h0) begin n_fail++; $display("FAIL rst_xy got %h want 0", {BestX2, BestY2}); end
    n_cmp++; if ({BestValid2, Count2, Busy2, Done2} !== 20'h0) begin n_fail++; $display("FAIL rst_ctrl got %h want 0", {BestValid2, Count2, Busy2, Done2}); end
    @(posedge Clk); #1;
    Rst = 1'b0;
    step();
    n_cmp++; if ({Busy2, Done2, Count2} !== 18'h0) begin n_fail++; $display("FAIL idle_after_rst got %h want 0", {Busy2, Done2, Count2}); end
  endtask

  task automatic test_basic();
    do_start();
    n_cmp++; if ({Busy2, Done2, Count2, BestValid2} !== {1'b1, 1'b0, 16'd0, 2'b00}) begin n_fail++; $display("FAIL start_state got %h want %h", {Busy2, Done2, Count2, BestValid2}, {1'b1, 1'b0, 16'd0, 2'b00}); end
    send(32'd50, 32'd1, 32'd1, 1'b0);
    n_cmp++; if ({BestSad2, BestValid2, Count2} !== {ONES, 32'd50, 2'b01, 16'd1}) begin n_fail++; $display("FAIL first_cand got %h want %h", {BestSad2, BestValid2, Count2}, {ONES, 32'd50, 2'b01, 16'd1}); end
    send(32'd30, 32'd2, 32'd2, 1'b0);
    send(32'd40, 32'd3, 32'd3, 1'b0);
    n_cmp++; if (BestSad2 !== {32'd40, 32'd30}) begin n_fail++; $display("FAIL mid_insert got %h want %h", BestSad2, {32'd40, 32'd30}); end
    n_cmp++; if (Done2 !== 1'b0 || Busy2 !== 1'b1) begin n_fail++; $display("FAIL busy_before_last got %b%b want 01", Done2, Busy2); end
    send(32'd10, 32'd4, 32'd4, 1'b1);
    n_cmp++; if ({Done2, Busy2} !== 2'b10) begin n_fail++; $display("FAIL done_flag got %b want 10", {Done2, Busy2}); end
    n_cmp++; if (BestSad2 !== {32'd30, 32'd10}) begin n_fail++; $display("FAIL basic_sad got %h want %h", BestSad2, {32'd30, 32'd10}); end
    n_cmp++; if ({BestX2, BestY2} !== {32'd2, 32'd4, 32'd2, 32'd4}) begin n_fail++; $display("FAIL basic_xy got %h want %h", {BestX2, BestY2}, {32'd2, 32'd4, 32'd2, 32'd4}); end
    n_cmp++; if ({BestValid2, Count2} !== {2'b11, 16'd4}) begin n_fail++; $display("FAIL basic_cnt got %h want %h", {BestValid2, Count2}, {2'b11, 16'd4}); end
    // InValid in DONE is ignored
    send(32'd1, 32'd7, 32'd7, 1'b0);
    n_cmp++; if ({BestSad2, Count2, Done2} !== {32'd30, 32'd10, 16'd4, 1'b1}) begin n_fail++; $display("FAIL done_ignores got %h want %h", {BestSad2, Count2, Done2}, {32'd30, 32'd10, 16'd4, 1'b1}); end
  endtask

  task automatic test_tie();
    do_start();
    send(32'd20, 32'd0, 32'd0, 1'b0);
    send(32'd20, 32'd5, 32'd5, 1'b1);
    n_cmp++; if ({BestSad1, BestX1, BestY1, Count1} !== {32'd20, 32'd0, 32'd0, 2'd2}) begin n_fail++; $display("FAIL tie_k1 got %h want %h", {BestSad1, BestX1, BestY1, Count1}, {32'd20, 32'd0, 32'd0, 2'd2}); end
    n_cmp++; if (BestX2 !== {32'd5, 32'd0}) begin n_fail++; $display("FAIL tie_order got %h want %h", BestX2, {32'd5, 32'd0}); end
  endtask

  task automatic test_sparse();
    do_start();
    step();
    n_cmp++; if ({Done2, Count2} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL sparse_idle got %h want 0", {Done2, Count2}); end
    send(32'd7, 32'd3, 32'd9, 1'b1);
    n_cmp++; if ({Done2, BestValid2, Count2} !== {1'b1, 2'b01, 16'd1}) begin n_fail++; $display("FAIL sparse_done got %h want %h", {Done2, BestValid2, Count2}, {1'b1, 2'b01, 16'd1}); end
    n_cmp++; if ({BestSad2, BestX2[31:0], BestY2[31:0]} !== {ONES, 32'd7, 32'd3, 32'd9}) begin n_fail++; $display("FAIL sparse_slots got %h want %h", {BestSad2, BestX2[31:0], BestY2[31:0]}, {ONES, 32'd7, 32'd3, 32'd9}); end
  endtask

  task automatic test_restart();
    do_start();
    send(32'd60, 32'd1, 32'd1, 1'b0);
    send(32'd70, 32'd2, 32'd2, 1'b0);
    Start = 1'b1; InValid = 1'b1; InSad = 32'd1; InX = 32'd8; InY = 32'd8;
    step();
    Start = 1'b0; InValid = 1'b0;
    n_cmp++; if ({BestSad2, BestValid2, Count2, Busy2} !== {ONES, ONES, 2'b00, 16'd0, 1'b1}) begin n_fail++; $display("FAIL restart_clear got %h want %h", {BestSad2, BestValid2, Count2, Busy2}, {ONES, ONES, 2'b00, 16'd0, 1'b1}); end
    send(32'd5, 32'd1, 32'd2, 1'b1);
    n_cmp++; if ({BestSad2[31:0], BestX2[31:0], Count2, Done2} !== {32'd5, 32'd1, 16'd1, 1'b1}) begin n_fail++; $display("FAIL restart_next got %h want %h", {BestSad2[31:0], BestX2[31:0], Count2, Done2}, {32'd5, 32'd1, 16'd1, 1'b1}); end
  endtask

  task automatic test_async_reset();
    do_start();
    send(32'd9, 32'd4, 32'd4, 1'b0);
    #3 Rst = 1'b1;
    #1;
    n_cmp++; if ({BestSad2, BestValid2, Count2, Busy2, Done2} !== {ONES, ONES, 2'b00, 16'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL async_rst got %h want %h", {BestSad2, BestValid2, Count2, Busy2, Done2}, {ONES, ONES, 2'b00, 16'd0, 1'b0, 1'b0}); end
    step();
    Rst = 1'b0;
    // InValid in IDLE is ignored
    send(32'd3, 32'd3, 32'd3, 1'b1);
    n_cmp++; if ({BestValid2, Count2, Done2, Busy2} !== 20'h0) begin n_fail++; $display("FAIL idle_ignores got %h want 0", {BestValid2, Count2, Done2, Busy2}); end
    do_start();
    send(32'd4, 32'd6, 32'd6, 1'b1);
    n_cmp++; if ({BestSad2[31:0], Count2, Done2} !== {32'd4, 16'd1, 1'b1}) begin n_fail++; $display("FAIL post_rst_search got %h want %h", {BestSad2[31:0], Count2, Done2}, {32'd4, 16'd1, 1'b1}); end
  endtask

  task automatic test_all_ones();
    do_start();
    send(ONES, 32'd1, 32'd1, 1'b0);
    send(ONES, 32'd2, 32'd2, 1'b0);
    send(ONES, 32'd3, 32'd3, 1'b1);
    n_cmp++; if ({BestValid2, Count2, Done2} !== {2'b00, 16'd3, 1'b1}) begin n_fail++; $display("FAIL ones_cnt got %h want %h", {BestValid2, Count2, Done2}, {2'b00, 16'd3, 1'b1}); end
    n_cmp++; if ({BestSad2, BestX2} !== {ONES, ONES, 64'h0}) begin n_fail++; $display("FAIL ones_slots got %h want %h", {BestSad2, BestX2}, {ONES, ONES, 64'h0}); end
  endtask

  task automatic test_count_sat();
    do_start();
    for (int i = 0; i < 5; i++) send(32'd100 + i, i, i, (i == 4));
    n_cmp++; if ({Count1, Count2} !== {2'd3, 16'd5}) begin n_fail++; $display("FAIL cnt_sat got %h want %h", {Count1, Count2}, {2'd3, 16'd5}); end
    n_cmp++; if ({BestSad1, BestSad2} !== {32'd100, 32'd101, 32'd100}) begin n_fail++; $display("FAIL sat_slots got %h want %h", {BestSad1, BestSad2}, {32'd100, 32'd101, 32'd100}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_sparse();
    test_restart();
    test_async_reset();
    test_all_ones();
    test_count_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
